// File: rtl/lifitx_ofdm_mapper_pkg.sv
// lifitx_ofdm_mapper_pkg: shared constants, types and helpers for the LiFi TX OFDM mapper.
//   - modulation encodings, IFFT size and bin-boundary constants
//   - default constellation amplitudes
//   - iq_t: packed {im, re} sample as carried on the IFFT stream
package lifitx_ofdm_mapper_pkg;

  localparam int unsigned NFFT         = 128;
  localparam int unsigned BIN_W        = 7;
  localparam int unsigned NSYM         = 32;
  localparam int unsigned SYM_IDX_W    = 5;
  localparam int unsigned BIN_LO_END   = 32;
  localparam int unsigned BIN_HI_START = 96;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned FRAME_W      = 128;
  localparam int unsigned SAMP_W       = 16;

  typedef enum logic [1:0] {
    MT_BPSK   = 2'd0,
    MT_QPSK   = 2'd1,
    MT_QAM16  = 2'd2,
    MT_QAM16B = 2'd3
  } mod_t;

  localparam logic signed [SAMP_W-1:0] AMP_BPSK    = 16'sd8192;
  localparam logic signed [SAMP_W-1:0] AMP_QPSK    = 16'sd5793;
  localparam logic signed [SAMP_W-1:0] AMP_QAM16   = 16'sd2590;
  localparam logic signed [SAMP_W-1:0] AMP_QAM16_3 = 16'(3 * AMP_QAM16);

  typedef struct packed {
    logic signed [SAMP_W-1:0] im;
    logic signed [SAMP_W-1:0] re;
  } iq_t;

  // Gray-coded 16-QAM axis level: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
  function automatic logic signed [SAMP_W-1:0] qam_level(input logic [1:0] b);
    case (b)
      2'b00:   return -AMP_QAM16_3;
      2'b01:   return -AMP_QAM16;
      2'b11:   return AMP_QAM16;
      default: return AMP_QAM16_3;
    endcase
  endfunction

  // Index of the last payload word for a modulation (words per frame minus one)
  function automatic logic [1:0] last_word_idx(input logic [1:0] mt);
    case (mt)
      MT_BPSK: return 2'd0;
      MT_QPSK: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lifitx_ofdm_mapper_if.sv
// lifitx_ofdm_mapper_if: AXI4-stream bundle (tdata/tvalid/tready/tlast) for the mapper.
//   master: drives tdata, tvalid, tlast; receives tready
//   slave : receives tdata, tvalid, tlast; drives tready
interface lifitx_ofdm_mapper_if ();
  import lifitx_ofdm_mapper_pkg::*;

  logic [WORD_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lifitx_ofdm_mapper_sym_map.sv
// lifitx_sym_map: combinational constellation mapper, (mt, 4 payload bits) -> {im, re}.
//   i_mt     : latched modulation type
//   i_bits   : symbol bits, LSB first; only the low bps bits are used
//   o_sym_c  : mapped symbol (combinational)
module lifitx_sym_map
  import lifitx_ofdm_mapper_pkg::*;
(
  input  logic [1:0] i_mt,
  input  logic [3:0] i_bits,
  output iq_t        o_sym_c
);

  always_comb begin
    o_sym_c = '0;
    case (i_mt)
      MT_BPSK: begin
        o_sym_c.re = i_bits[0] ? AMP_BPSK : -AMP_BPSK;
      end
      MT_QPSK: begin
        o_sym_c.re = i_bits[0] ? AMP_QPSK : -AMP_QPSK;
        o_sym_c.im = i_bits[1] ? AMP_QPSK : -AMP_QPSK;
      end
      default: begin
        o_sym_c.re = qam_level(i_bits[1:0]);
        o_sym_c.im = qam_level(i_bits[3:2]);
      end
    endcase
  end

endmodule

// File: rtl/lifitx_ofdm_mapper.sv
// lifitx_ofdm_mapper: collects a 1/2/4-word payload, maps it onto 32 subcarrier symbols
// and streams a Hermitian-symmetric 128-bin frame to the IFFT.
//   aclk, aresetn : clock, synchronous active-low reset
//   i_mod_type    : 0 BPSK, 1 QPSK, 2/3 16-QAM; sampled on the first payload word
//   s_axis        : payload stream in (slave)
//   m_axis        : frequency-domain bins out, tdata = {im, re} (master)
//   o_frame_done  : one-cycle pulse on the bin-127 handshake
//   o_err_tick    : one-cycle pulse when tlast disagrees with the expected frame length
module lifitx_ofdm_mapper
  import lifitx_ofdm_mapper_pkg::*;
(
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [1:0]                   i_mod_type,
  lifitx_ofdm_mapper_if.slave          s_axis,
  lifitx_ofdm_mapper_if.master         m_axis,
  output logic                         o_frame_done,
  output logic                         o_err_tick
);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_EMIT    = 1'b1;
  localparam logic [BIN_W-1:0] K_LAST = BIN_W'(NFFT - 1);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [BIN_W-1:0]   r_k;
  logic [1:0]         r_w;
  logic [1:0]         r_mt;
  logic [FRAME_W-1:0] r_frame;
  logic               r_s_tready;
  logic               r_m_tvalid;
  logic               r_m_tlast;
  iq_t                r_m_tdata;
  logic               r_frame_done;
  logic               r_err_tick;

  logic               w_s_hs;
  logic               w_m_hs;
  logic [1:0]         w_mt_eff;
  logic               w_last_exp;
  logic               w_exit;
  logic               w_err;
  logic               w_wrap;
  logic [BIN_W-1:0]   w_k_nxt;
  logic [SYM_IDX_W-1:0] w_sym_idx;
  logic               w_in_band;
  logic               w_conj;
  logic [BIN_W-1:0]   w_sh;
  logic [3:0]         w_bits;
  iq_t                w_sym;
  iq_t                w_bin;

  assign s_axis.tready = r_s_tready;
  assign m_axis.tvalid = r_m_tvalid;
  assign m_axis.tlast  = r_m_tlast;
  assign m_axis.tdata  = r_m_tdata;
  assign o_frame_done  = r_frame_done;
  assign o_err_tick    = r_err_tick;

  assign w_s_hs = s_axis.tvalid & r_s_tready;
  assign w_m_hs = r_m_tvalid & m_axis.tready;

  // The first word decides the frame length before mt is latched
  assign w_mt_eff   = (r_w == 2'd0) ? i_mod_type : r_mt;
  assign w_last_exp = (r_w == last_word_idx(w_mt_eff));

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_exit      = 1'b0;
    w_err       = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_s_hs && (w_last_exp || s_axis.tlast)) begin
          w_state_nxt = S_EMIT;
          w_exit      = 1'b1;
          w_err       = (s_axis.tlast != w_last_exp);
        end
      end
      default: begin
        if (w_m_hs && (r_k == K_LAST)) begin
          w_state_nxt = S_COLLECT;
          w_wrap      = 1'b1;
        end
      end
    endcase
  end

  // Bin value for k+1, registered on each output handshake.
  // Upper half mirrors the lower half: bin k uses symbol 127-k, conjugated.
  assign w_k_nxt = r_k + 1'b1;

  always_comb begin
    w_in_band = 1'b0;
    w_conj    = 1'b0;
    w_sym_idx = '0;
    if ((w_k_nxt >= BIN_W'(1)) && (w_k_nxt <= BIN_W'(BIN_LO_END))) begin
      w_in_band = 1'b1;
      w_sym_idx = SYM_IDX_W'(w_k_nxt - BIN_W'(1));
    end else if (w_k_nxt >= BIN_W'(BIN_HI_START)) begin
      w_in_band = 1'b1;
      w_conj    = 1'b1;
      w_sym_idx = SYM_IDX_W'(K_LAST - w_k_nxt);
    end
  end

  always_comb begin
    case (r_mt)
      MT_BPSK: w_sh = {2'b00, w_sym_idx};
      MT_QPSK: w_sh = {1'b0, w_sym_idx, 1'b0};
      default: w_sh = {w_sym_idx, 2'b00};
    endcase
  end

  assign w_bits = 4'(r_frame >> w_sh);

  lifitx_sym_map u_sym_map (
    .i_mt    (r_mt),
    .i_bits  (w_bits),
    .o_sym_c (w_sym)
  );

  always_comb begin
    w_bin = '0;
    if (w_in_band) begin
      w_bin.re = w_sym.re;
      w_bin.im = w_conj ? -w_sym.im : w_sym.im;
    end
  end

  // State and datapath registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= S_COLLECT;
      r_k          <= '0;
      r_w          <= '0;
      r_mt         <= '0;
      r_frame      <= '0;
      r_s_tready   <= 1'b1;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tdata    <= '0;
      r_frame_done <= 1'b0;
      r_err_tick   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_wrap;
      r_err_tick   <= w_err;

      if (w_s_hs) begin
        r_frame[WORD_W*r_w +: WORD_W] <= s_axis.tdata;
        if (r_w == 2'd0) r_mt <= i_mod_type;
        r_w <= w_exit ? 2'd0 : r_w + 2'd1;
      end

      // Bin 0 is DC and always zero
      if (w_exit) begin
        r_s_tready <= 1'b0;
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= '0;
        r_m_tlast  <= 1'b0;
        r_k        <= '0;
      end

      if (w_m_hs) begin
        if (w_wrap) begin
          r_s_tready <= 1'b1;
          r_m_tvalid <= 1'b0;
          r_m_tlast  <= 1'b0;
          r_m_tdata  <= '0;
          r_k        <= '0;
          r_frame    <= '0;
        end else begin
          r_k       <= w_k_nxt;
          r_m_tdata <= w_bin;
          r_m_tlast <= (w_k_nxt == K_LAST);
        end
      end
    end
  end

endmodule
